// File: rtl/regpair_file.sv
// regpair_file: byte register file with a 16-bit pair view, SP/PSW top pair, masked flag byte and PC.
// Defining REGFILE_BYPASS_EN forwards same-cycle byte writes and pair loads to rd_data/rp_data.
module regpair_file #(
  parameter int DATASIZE = 8,
  parameter int REGSBITS = 3,
  parameter int FLAGIDX = 6,
  parameter logic [DATASIZE-1:0] FLAGMASK = 8'b11010101
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      wr_enb,
  input  logic [REGSBITS-1:0]       wr_addr,
  input  logic [DATASIZE-1:0]       wr_data,
  input  logic [REGSBITS-1:0]       rd_addr,
  output logic [DATASIZE-1:0]       rd_data,
  input  logic [REGSBITS-2:0]       rp_addr,
  input  logic                      rp_psw,
  input  logic [1:0]                rp_op,
  input  logic [2*DATASIZE-1:0]     rp_wdat,
  output logic [2*DATASIZE-1:0]     rp_data,
  output logic                      rp_wrap,
  input  logic [1:0]                pc_op,
  input  logic [2*DATASIZE-1:0]     pc_ld,
  output logic [2*DATASIZE-1:0]     pc_out,
  output logic [2*DATASIZE-1:0]     sp_out
);

  localparam int REGCOUNT = 2**REGSBITS;
  localparam int PAIRSIZE = 2*DATASIZE;
  localparam int REGPBITS = REGSBITS-1;
  localparam logic [REGPBITS-1:0] PAIR_TOP  = {REGPBITS{1'b1}};
  localparam logic [REGSBITS-1:0] FLAG_LO   = REGSBITS'(FLAGIDX);
  localparam logic [REGSBITS-1:0] FLAG_HI   = REGSBITS'(FLAGIDX + 1);
  localparam logic [PAIRSIZE-1:0] PAIR_ZERO = {PAIRSIZE{1'b0}};
  localparam logic [PAIRSIZE-1:0] PAIR_ONES = {PAIRSIZE{1'b1}};
  localparam logic [PAIRSIZE-1:0] PAIR_ONE  = {{(PAIRSIZE-1){1'b0}}, 1'b1};

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LD   = 2'b10;
  localparam logic [1:0] PC_RP   = 2'b11;

  // Every store into the flag byte keeps only its writable bits.
  function automatic logic [DATASIZE-1:0] store_byte(input logic [REGSBITS-1:0] idx,
                                                     input logic [DATASIZE-1:0] data);
    logic [DATASIZE-1:0] res;
    if (idx == FLAG_LO) res = data & FLAGMASK;
    else                res = data;
    return res;
  endfunction

  logic [DATASIZE-1:0] regs_r      [REGCOUNT];
  logic [DATASIZE-1:0] fwd_regs_s  [REGCOUNT];
  logic [DATASIZE-1:0] nxt_regs_s  [REGCOUNT];
  logic [DATASIZE-1:0] view_regs_s [REGCOUNT];
  logic [PAIRSIZE-1:0] sp_r, sp_fwd_s, sp_nxt_s, sp_view_s;
  logic [PAIRSIZE-1:0] pc_r, pc_nxt_s;
  logic [PAIRSIZE-1:0] pair_cur_s, incdec_s;
  logic [REGSBITS-1:0] hi_idx_s, lo_idx_s;
  logic                top_s, sel_sp_s, pair_act_s, incdec_act_s, hit_s, wrap_s, wrap_r;

  // Decode the selected pair, its current value, the inc/dec result and collision with the byte write
  always_comb begin
    top_s        = (rp_addr == PAIR_TOP);
    sel_sp_s     = top_s && !rp_psw;
    pair_act_s   = (rp_op != OP_NONE);
    incdec_act_s = (rp_op == OP_INC) || (rp_op == OP_DEC);
    if (top_s) begin
      hi_idx_s = FLAG_HI;
      lo_idx_s = FLAG_LO;
    end else begin
      hi_idx_s = {rp_addr, 1'b0};
      lo_idx_s = {rp_addr, 1'b1};
    end
    // SP holds no byte registers, so it can never collide with a byte write
    hit_s = pair_act_s && !sel_sp_s && ((wr_addr == hi_idx_s) || (wr_addr == lo_idx_s));
    if (sel_sp_s) pair_cur_s = sp_r;
    else          pair_cur_s = {regs_r[hi_idx_s], regs_r[lo_idx_s]};
    case (rp_op)
      OP_INC:  incdec_s = pair_cur_s + PAIR_ONE;
      OP_DEC:  incdec_s = pair_cur_s - PAIR_ONE;
      default: incdec_s = pair_cur_s;
    endcase
    wrap_s = ((rp_op == OP_INC) && (pair_cur_s == PAIR_ONES)) ||
             ((rp_op == OP_DEC) && (pair_cur_s == PAIR_ZERO));
  end

  // Next register state: byte write and pair load form the forwardable view, inc/dec lands on top
  always_comb begin
    for (int i = 0; i < REGCOUNT; i++) begin
      if ((rp_op == OP_LOAD) && !sel_sp_s && (hi_idx_s == REGSBITS'(i)))
        fwd_regs_s[i] = store_byte(REGSBITS'(i), rp_wdat[PAIRSIZE-1:DATASIZE]);
      else if ((rp_op == OP_LOAD) && !sel_sp_s && (lo_idx_s == REGSBITS'(i)))
        fwd_regs_s[i] = store_byte(REGSBITS'(i), rp_wdat[DATASIZE-1:0]);
      else if (wr_enb && !hit_s && (wr_addr == REGSBITS'(i)))
        fwd_regs_s[i] = store_byte(REGSBITS'(i), wr_data);
      else
        fwd_regs_s[i] = regs_r[i];

      if (incdec_act_s && !sel_sp_s && (hi_idx_s == REGSBITS'(i)))
        nxt_regs_s[i] = store_byte(REGSBITS'(i), incdec_s[PAIRSIZE-1:DATASIZE]);
      else if (incdec_act_s && !sel_sp_s && (lo_idx_s == REGSBITS'(i)))
        nxt_regs_s[i] = store_byte(REGSBITS'(i), incdec_s[DATASIZE-1:0]);
      else
        nxt_regs_s[i] = fwd_regs_s[i];
    end
    if (sel_sp_s && (rp_op == OP_LOAD)) sp_fwd_s = rp_wdat;
    else                                sp_fwd_s = sp_r;
    if (sel_sp_s && incdec_act_s) sp_nxt_s = incdec_s;
    else                          sp_nxt_s = sp_fwd_s;
  end

  // Read ports: stored contents, or the forwarded view when bypassing is built in
  always_comb begin
    for (int i = 0; i < REGCOUNT; i++) begin
`ifdef REGFILE_BYPASS_EN
      view_regs_s[i] = fwd_regs_s[i];
`else
      view_regs_s[i] = regs_r[i];
`endif
    end
`ifdef REGFILE_BYPASS_EN
    sp_view_s = sp_fwd_s;
`else
    sp_view_s = sp_r;
`endif
    rd_data = view_regs_s[rd_addr];
    if (sel_sp_s) rp_data = sp_view_s;
    else          rp_data = {view_regs_s[hi_idx_s], view_regs_s[lo_idx_s]};
  end

  // Program counter next value; PCHL takes the pre-edge pair read
  always_comb begin
    case (pc_op)
      PC_HOLD: pc_nxt_s = pc_r;
      PC_INC:  pc_nxt_s = pc_r + PAIR_ONE;
      PC_LD:   pc_nxt_s = pc_ld;
      PC_RP:   pc_nxt_s = rp_data;
      default: pc_nxt_s = pc_r;
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < REGCOUNT; i++) regs_r[i] <= {DATASIZE{1'b0}};
      sp_r   <= PAIR_ZERO;
      pc_r   <= PAIR_ZERO;
      wrap_r <= 1'b0;
    end else begin
      for (int i = 0; i < REGCOUNT; i++) regs_r[i] <= nxt_regs_s[i];
      sp_r   <= sp_nxt_s;
      pc_r   <= pc_nxt_s;
      wrap_r <= wrap_s;
    end
  end

  assign pc_out  = pc_r;
  assign sp_out  = sp_r;
  assign rp_wrap = wrap_r;

endmodule
